// File: rtl/pc_pkg.sv
// -----------------------------------------------------------------------------
// pc_pkg
// Shared constants and helpers for the program counter unit.
//   STEP_BYTE / STEP_WORD : the only legal sequential increments.
//   align_mask(step)      : low address bits that must be zero for a branch
//                           target to be accepted at the given step.
//   ras_ptr_width(depth)  : pointer width for a return-address stack.
// -----------------------------------------------------------------------------
package pc_pkg;

   localparam int STEP_BYTE = 1;
   localparam int STEP_WORD = 4;

   // Word-stepping cores reject targets that are not 4-byte aligned;
   // byte-stepping cores accept any target.
   function automatic logic [1:0] align_mask(input int step);
      return (step == STEP_WORD) ? 2'b11 : 2'b00;
   endfunction

   // Clamped at 1 so a degenerate depth never yields a zero-width pointer.
   function automatic int ras_ptr_width(input int depth);
      return (depth < 2) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/return_address_stack.sv
// -----------------------------------------------------------------------------
// return_address_stack
// Circular return-address stack with a top pointer and a saturating
// occupancy count. A push into a full stack overwrites the oldest entry and
// pulses overflow; a pop from an empty stack is ignored. push and pop
// together replace the top entry (a plain push when empty). flush empties it.
// Ports:
//   clk, reset (async, active-low)
//   push, pop, flush        : operation strobes (flush has priority)
//   push_data [XLEN]        : value written by push
//   top [XLEN]              : top entry, 0 when empty
//   valid                   : stack non-empty
//   overflow                : one-cycle pulse, oldest entry overwritten
// -----------------------------------------------------------------------------
module return_address_stack
   import pc_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int RAS_DEPTH = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            push,
   input  logic            pop,
   input  logic            flush,
   input  logic [XLEN-1:0] push_data,
   output logic [XLEN-1:0] top,
   output logic            valid,
   output logic            overflow
);

   localparam int PW = ras_ptr_width(RAS_DEPTH);
   localparam logic [PW:0] FULL = (PW + 1)'(RAS_DEPTH);

   logic [XLEN-1:0] mem [RAS_DEPTH];
   logic [PW-1:0]   top_ptr;
   logic [PW-1:0]   next_ptr;
   logic [PW:0]     count;
   logic            replace;

   // Depth is a power of two, so the pointer wraps naturally.
   assign next_ptr = top_ptr + 1'b1;
   assign replace  = push & pop & (count != '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         top_ptr  <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         overflow <= 1'b0;
         if (flush) begin
            count <= '0;
         end else if (replace) begin
            // top entry rewritten below; pointer and count unchanged
         end else if (push) begin
            top_ptr <= next_ptr;
            if (count == FULL) overflow <= 1'b1;
            else               count    <= count + 1'b1;
         end else if (pop && count != '0) begin
            top_ptr <= top_ptr - 1'b1;
            count   <= count - 1'b1;
         end
      end
   end

   // Entry contents carry no reset; count alone decides what is visible.
   always_ff @(posedge clk) begin
      if (!flush && push) begin
         if (replace) mem[top_ptr]  <= push_data;
         else         mem[next_ptr] <= push_data;
      end
   end

   assign valid = (count != '0);
   assign top   = valid ? mem[top_ptr] : '0;

endmodule

// File: rtl/program_counter_unit.sv
// -----------------------------------------------------------------------------
// program_counter_unit
// Program counter with trap / branch / sequential update and a
// return-address stack for call/ret prediction.
// Update priority each edge: trap, then stall (hold), then branch, then
// sequential increment. A misaligned branch target holds the PC, pulses
// misaligned and suppresses call/ret for that cycle.
// Ports:
//   clk, reset (async, active-low)
//   stall, branch_taken, branch_target, trap, trap_vector, call, ret : controls
//   pc_out        : current PC
//   pc_prev       : PC value before the last change
//   misaligned    : one-cycle pulse, branch target rejected
//   ras_target    : top-of-stack return address (0 when empty)
//   ras_valid     : stack non-empty
//   ras_overflow  : one-cycle pulse, oldest stack entry overwritten
// All outputs come from registers (or a register-selected mux).
// -----------------------------------------------------------------------------
module program_counter_unit
   import pc_pkg::*;
#(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter int              STEP         = STEP_WORD,
   parameter int              RAS_DEPTH    = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall,
   input  logic            branch_taken,
   input  logic [XLEN-1:0] branch_target,
   input  logic            trap,
   input  logic [XLEN-1:0] trap_vector,
   input  logic            call,
   input  logic            ret,
   output logic [XLEN-1:0] pc_out,
   output logic [XLEN-1:0] pc_prev,
   output logic            misaligned,
   output logic [XLEN-1:0] ras_target,
   output logic            ras_valid,
   output logic            ras_overflow
);

   localparam logic [XLEN-1:0] STEP_V = XLEN'(STEP);

   logic [XLEN-1:0] seq_pc;
   logic [XLEN-1:0] pc_next;
   logic            active;
   logic            bad_branch;
   logic            ras_ok;

   // Sequential address doubles as the return address pushed by call.
   assign seq_pc     = pc_out + STEP_V;
   assign active     = ~trap & ~stall;
   assign bad_branch = active & branch_taken & (|(branch_target[1:0] & align_mask(STEP)));
   assign ras_ok     = active & ~bad_branch;

   always_comb begin
      pc_next = pc_out;
      if (trap) begin
         pc_next = trap_vector;
      end else if (ras_ok) begin
         pc_next = branch_taken ? branch_target : seq_pc;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_out     <= RESET_VECTOR;
         pc_prev    <= RESET_VECTOR;
         misaligned <= 1'b0;
      end else begin
         misaligned <= bad_branch;
         // pc_prev tracks value changes only, so a hold or a redirect to the
         // current address leaves it untouched.
         if (pc_next != pc_out) begin
            pc_prev <= pc_out;
            pc_out  <= pc_next;
         end
      end
   end

   return_address_stack #(
      .XLEN      (XLEN),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .reset     (reset),
      .push      (call & ras_ok),
      .pop       (ret & ras_ok),
      .flush     (trap),
      .push_data (seq_pc),
      .top       (ras_target),
      .valid     (ras_valid),
      .overflow  (ras_overflow)
   );

endmodule

// File: tb/tb_program_counter_unit.sv
// -----------------------------------------------------------------------------
// tb_program_counter_unit
// Drives a 32-bit and an 8-bit instance from the same control inputs.
// A list-based model (stack as a plain array, top at the highest index)
// predicts every output each cycle; directed literal checks pin the model.
// -----------------------------------------------------------------------------
module tb_program_counter_unit;

   localparam int D = 4;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        trap;
   logic [31:0] trap_vector;
   logic        call;
   logic        ret;

   logic [31:0] pc_out32, pc_prev32, ras_target32;
   logic        misaligned32, ras_valid32, ras_overflow32;
   logic [7:0]  pc_out8, pc_prev8, ras_target8;
   logic        misaligned8, ras_valid8, ras_overflow8;

   int checks = 0;
   int errors = 0;
   bit run_chk = 0;
   logic [31:0] exp_q[$];

   program_counter_unit #(.XLEN(32)) dut32 (
      .clk           (clk),
      .reset         (reset),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .trap          (trap),
      .trap_vector   (trap_vector),
      .call          (call),
      .ret           (ret),
      .pc_out        (pc_out32),
      .pc_prev       (pc_prev32),
      .misaligned    (misaligned32),
      .ras_target    (ras_target32),
      .ras_valid     (ras_valid32),
      .ras_overflow  (ras_overflow32)
   );

   program_counter_unit #(.XLEN(8)) dut8 (
      .clk           (clk),
      .reset         (reset),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target[7:0]),
      .trap          (trap),
      .trap_vector   (trap_vector[7:0]),
      .call          (call),
      .ret           (ret),
      .pc_out        (pc_out8),
      .pc_prev       (pc_prev8),
      .misaligned    (misaligned8),
      .ras_target    (ras_target8),
      .ras_valid     (ras_valid8),
      .ras_overflow  (ras_overflow8)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- model ----------------
   logic [31:0] m_pc   [2];
   logic [31:0] m_prev [2];
   logic        m_mis  [2];
   logic        m_ovf  [2];
   logic [31:0] m_stk  [2][D];
   int          m_cnt  [2];

   function automatic logic [31:0] msk(input int m);
      return (m == 0) ? 32'hFFFF_FFFF : 32'h0000_00FF;
   endfunction

   function automatic logic [31:0] m_top(input int m);
      return (m_cnt[m] > 0) ? m_stk[m][m_cnt[m]-1] : 32'h0;
   endfunction

   task automatic model_reset(input int m);
      m_pc[m]   = 32'h0;
      m_prev[m] = 32'h0;
      m_mis[m]  = 1'b0;
      m_ovf[m]  = 1'b0;
      m_cnt[m]  = 0;
   endtask

   task automatic model_step(input int m);
      logic [31:0] k, old, nxt, ret_addr;
      k        = msk(m);
      old      = m_pc[m];
      nxt      = old;
      ret_addr = (old + 32'd4) & k;
      m_mis[m] = 1'b0;
      m_ovf[m] = 1'b0;
      if (trap) begin
         nxt      = trap_vector & k;
         m_cnt[m] = 0;
      end else if (!stall) begin
         if (branch_taken && branch_target[1:0] != 2'b00) begin
            m_mis[m] = 1'b1;
         end else begin
            nxt = branch_taken ? (branch_target & k) : ret_addr;
            if (call && ret && m_cnt[m] > 0) begin
               m_stk[m][m_cnt[m]-1] = ret_addr;
            end else if (call) begin
               if (m_cnt[m] == D) begin
                  for (int i = 0; i < D - 1; i++) m_stk[m][i] = m_stk[m][i+1];
                  m_stk[m][D-1] = ret_addr;
                  m_ovf[m]      = 1'b1;
               end else begin
                  m_stk[m][m_cnt[m]] = ret_addr;
                  m_cnt[m]++;
               end
            end else if (ret && m_cnt[m] > 0) begin
               m_cnt[m]--;
            end
         end
      end
      if (nxt != old) begin
         m_prev[m] = old;
         m_pc[m]   = nxt;
      end
   endtask

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         model_reset(0);
         model_reset(1);
      end else begin
         model_step(0);
         model_step(1);
      end
   end

   // ---------------- scoreboard ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (run_chk && reset) begin
         chk("pc32",   pc_out32,                m_pc[0]);
         chk("prev32", pc_prev32,               m_prev[0]);
         chk("mis32",  {31'h0, misaligned32},   {31'h0, m_mis[0]});
         chk("ovf32",  {31'h0, ras_overflow32}, {31'h0, m_ovf[0]});
         chk("val32",  {31'h0, ras_valid32},    {31'h0, m_cnt[0] != 0});
         chk("top32",  ras_target32,            m_top(0));
         chk("pc8",    {24'h0, pc_out8},        m_pc[1]);
         chk("prev8",  {24'h0, pc_prev8},       m_prev[1]);
         chk("mis8",   {31'h0, misaligned8},    {31'h0, m_mis[1]});
         chk("ovf8",   {31'h0, ras_overflow8},  {31'h0, m_ovf[1]});
         chk("val8",   {31'h0, ras_valid8},     {31'h0, m_cnt[1] != 0});
         chk("top8",   {24'h0, ras_target8},    m_top(1));
      end
   end

   // ---------------- driver ----------------
   task automatic drive(input logic st, input logic br, input logic [31:0] bt,
                        input logic tr, input logic [31:0] tv,
                        input logic c, input logic r);
      stall         = st;
      branch_taken  = br;
      branch_target = bt;
      trap          = tr;
      trap_vector   = tv;
      call          = c;
      ret           = r;
      @(posedge clk);
      #1;
      stall         = 1'b0;
      branch_taken  = 1'b0;
      branch_target = 32'h0;
      trap          = 1'b0;
      trap_vector   = 32'h0;
      call          = 1'b0;
      ret           = 1'b0;
   endtask

   task automatic idle();
      drive(0, 0, 32'h0, 0, 32'h0, 0, 0);
   endtask

   task automatic branch_to(input logic [31:0] t);
      drive(0, 1, t, 0, 32'h0, 0, 0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      reset         = 1'b0;
      stall         = 1'b0;
      branch_taken  = 1'b0;
      branch_target = 32'h0;
      trap          = 1'b0;
      trap_vector   = 32'h0;
      call          = 1'b0;
      ret           = 1'b0;

      // Reset held for three edges
      repeat (3) @(posedge clk);
      #1;
      chk("rst_pc",    pc_out32,                32'h0);
      chk("rst_prev",  pc_prev32,               32'h0);
      chk("rst_valid", {31'h0, ras_valid32},    32'h0);
      chk("rst_mis",   {31'h0, misaligned32},   32'h0);
      chk("rst_ovf",   {31'h0, ras_overflow32}, 32'h0);
      reset   = 1'b1;
      run_chk = 1'b1;

      // Free run: 4, 8, 12 with pc_prev one behind
      idle();
      chk("run_pc4",   pc_out32,  32'h4);
      chk("run_prev0", pc_prev32, 32'h0);
      idle();
      chk("run_pc8",   pc_out32,  32'h8);
      chk("run_prev4", pc_prev32, 32'h4);
      idle();
      chk("run_pc12",  pc_out32,  32'hC);
      chk("run_prev8", pc_prev32, 32'h8);

      // Call at 0xC pushes 0x10
      drive(0, 0, 32'h0, 0, 32'h0, 1, 0);
      chk("call_pc",  pc_out32,     32'h10);
      chk("call_top", ras_target32, 32'h10);

      // Trap beats stall and branch, and flushes the stack
      drive(1, 1, 32'h100, 1, 32'h80, 1, 0);
      chk("trap_pc",    pc_out32,             32'h80);
      chk("trap_prev",  pc_prev32,            32'h10);
      chk("trap_valid", {31'h0, ras_valid32}, 32'h0);

      // Stall holds and ignores call/ret
      drive(1, 0, 32'h0, 0, 32'h0, 1, 1);
      chk("stall_pc",    pc_out32,             32'h80);
      chk("stall_valid", {31'h0, ras_valid32}, 32'h0);

      // Misaligned branch at 0x20: hold, pulse, suppress call
      branch_to(32'h20);
      chk("br_pc", pc_out32, 32'h20);
      drive(0, 1, 32'h102, 0, 32'h0, 1, 0);
      chk("mis_pc",    pc_out32,              32'h20);
      chk("mis_flag",  {31'h0, misaligned32}, 32'h1);
      chk("mis_valid", {31'h0, ras_valid32},  32'h0);
      idle();
      chk("mis_next", pc_out32,              32'h24);
      chk("mis_drop", {31'h0, misaligned32}, 32'h0);

      // Five calls from 0x0: overflow on the fifth
      branch_to(32'h0);
      for (int i = 0; i < 5; i++) begin
         drive(0, 0, 32'h0, 0, 32'h0, 1, 0);
         chk("ovf_pulse", {31'h0, ras_overflow32}, {31'h0, i == 4});
      end
      chk("ovf_pc", pc_out32, 32'h14);

      exp_q.push_back(32'h14);
      exp_q.push_back(32'h10);
      exp_q.push_back(32'hC);
      exp_q.push_back(32'h8);
      while (exp_q.size() > 0) begin
         chk("ret_top", ras_target32, exp_q.pop_front());
         drive(0, 0, 32'h0, 0, 32'h0, 0, 1);
      end
      chk("ret_empty", {31'h0, ras_valid32}, 32'h0);
      chk("ret_zero",  ras_target32,         32'h0);
      // Pop of an empty stack is harmless
      drive(0, 0, 32'h0, 0, 32'h0, 0, 1);
      chk("pop_empty", {31'h0, ras_valid32}, 32'h0);

      // Call+ret replaces top 0x40 with 0x24, count stays at one
      branch_to(32'h3C);
      drive(0, 1, 32'h20, 0, 32'h0, 1, 0);
      chk("cr_pc0",  pc_out32,     32'h20);
      chk("cr_top0", ras_target32, 32'h40);
      drive(0, 0, 32'h0, 0, 32'h0, 1, 1);
      chk("cr_pc1",  pc_out32,             32'h24);
      chk("cr_top1", ras_target32,         32'h24);
      chk("cr_val1", {31'h0, ras_valid32}, 32'h1);
      drive(0, 0, 32'h0, 0, 32'h0, 0, 1);
      chk("cr_val2", {31'h0, ras_valid32}, 32'h0);

      // 8-bit wrap from 0xFC to 0x00
      branch_to(32'hFC);
      chk("wrap_pre", {24'h0, pc_out8}, 32'hFC);
      idle();
      chk("wrap_pc8",   {24'h0, pc_out8},  32'h00);
      chk("wrap_prev8", {24'h0, pc_prev8}, 32'hFC);
      chk("wrap_pc32",  pc_out32,          32'h100);

      idle();
      idle();
      @(negedge clk);
      run_chk = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
